// File: rtl/pc_fetch_controller.sv
// PC sequencer and instruction-memory fetch front end.
// One-entry output slot toward decode, redirect flush and sticky fault.
module pc_fetch_controller #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] PCResult,
    output logic [31:0] Instruction,
    output logic        InstrValid,
    output logic        Flush,
    output logic        Fault
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REDIR,
        FAULT
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_t            state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       pc_result_q;
    logic [31:0]       instr_q;
    logic              valid_q;
    logic              flush_q;
    logic              fault_q;
    logic [CNT_W-1:0]  wait_cnt_q;

    logic              redirect;
    logic [31:0]       target;
    logic              do_redirect;
    logic              slot_free;
    logic              consume;
    logic              req;
    logic              accept;
    logic              miss;
    logic [CNT_W-1:0]  wait_cnt_d;
    logic              timeout_hit;

    // Request, redirect and timeout decode for the current cycle.
    always_comb begin
        redirect    = BranchTaken | Jump;
        target      = BranchTaken ? BranchTarget : JumpTarget;
        do_redirect = redirect &&
                      ((state_q == REQ) || (state_q == REDIR));
        slot_free   = !valid_q || !Stall;
        consume     = valid_q && !Stall;
        req         = (state_q == REQ) && slot_free && !redirect;
        accept      = req && IMemReady;
        miss        = req && !IMemReady;
        wait_cnt_d  = wait_cnt_q + CNT_W'(1);
        timeout_hit = miss && (wait_cnt_d == TIMEOUT_C);
    end

    // Fetch FSM with registered decode-facing outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_ADDR;
            pc_result_q <= 32'h0;
            instr_q     <= 32'h0;
            valid_q     <= 1'b0;
            flush_q     <= 1'b0;
            fault_q     <= 1'b0;
            wait_cnt_q  <= '0;
        end else if (do_redirect) begin
            valid_q    <= 1'b0;
            wait_cnt_q <= '0;
            if (target[1:0] != 2'b00) begin
                fault_q <= 1'b1;
                flush_q <= 1'b0;
                state_q <= FAULT;
            end else begin
                fetch_pc_q <= target;
                flush_q    <= 1'b1;
                state_q    <= REDIR;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_q <= REQ;
                end
                REDIR: begin
                    flush_q <= 1'b0;
                    state_q <= REQ;
                end
                REQ: begin
                    flush_q <= 1'b0;
                    if (accept) begin
                        instr_q     <= IMemData;
                        pc_result_q <= fetch_pc_q;
                        valid_q     <= 1'b1;
                        fetch_pc_q  <= fetch_pc_q + 32'd4;
                        wait_cnt_q  <= '0;
                    end else begin
                        if (consume) begin
                            valid_q <= 1'b0;
                        end
                        if (miss) begin
                            wait_cnt_q <= wait_cnt_d;
                        end
                        if (timeout_hit) begin
                            fault_q <= 1'b1;
                            valid_q <= 1'b0;
                            state_q <= FAULT;
                        end
                    end
                end
                FAULT: begin
                    valid_q <= 1'b0;
                    flush_q <= 1'b0;
                    fault_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign IMemReq     = req;
    assign IMemAddr    = fetch_pc_q;
    assign PCResult    = pc_result_q;
    assign Instruction = instr_q;
    assign InstrValid  = valid_q;
    assign Flush       = flush_q;
    assign Fault       = fault_q;

endmodule

// File: tb/tb_pc_fetch_controller.sv
// Directed bench for pc_fetch_controller.
// Fetched words are tracked in an expected-result queue.
module tb_pc_fetch_controller;

    logic        Clk = 1'b0;
    logic        Reset, Reset_w;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        IMemReady;
    logic [31:0] IMemData, IMemData_w;
    logic        IMemReq, IMemReq_w;
    logic [31:0] IMemAddr, IMemAddr_w;
    logic [31:0] PCResult, PCResult_w;
    logic [31:0] Instruction, Instruction_w;
    logic        InstrValid, InstrValid_w;
    logic        Flush, Flush_w;
    logic        Fault, Fault_w;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_pc;
    int          passed = 0;
    int          failed = 0;
    int          total  = 0;

    always #5 Clk = ~Clk;

    pc_fetch_controller dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .IMemReady(IMemReady), .IMemData(IMemData),
        .IMemReq(IMemReq), .IMemAddr(IMemAddr),
        .PCResult(PCResult), .Instruction(Instruction),
        .InstrValid(InstrValid), .Flush(Flush), .Fault(Fault)
    );

    pc_fetch_controller #(.RESET_ADDR(32'hFFFF_FFF8)) dut_w (
        .Clk(Clk), .Reset(Reset_w), .Stall(Stall),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
        .Jump(Jump), .JumpTarget(JumpTarget),
        .IMemReady(IMemReady), .IMemData(IMemData_w),
        .IMemReq(IMemReq_w), .IMemAddr(IMemAddr_w),
        .PCResult(PCResult_w), .Instruction(Instruction_w),
        .InstrValid(InstrValid_w), .Flush(Flush_w), .Fault(Fault_w)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Settle, answer memory, run the scoreboard for this cycle.
    task automatic sample();
        exp_t e;
        #1;
        IMemData   = word(IMemAddr);
        IMemData_w = word(IMemAddr_w);
        #1;
        if (Reset) begin
            sbq.delete();
            exp_pc = 32'h0;
        end else begin
            if (InstrValid && !Stall) begin
                check("sb_nonempty", {31'b0, sbq.size() != 0}, 32'd1);
                if (sbq.size() != 0) begin
                    e = sbq.pop_front();
                    check("sb_pc", PCResult, e.pc);
                    check("sb_instr", Instruction, e.ins);
                end
            end
            if (IMemReq && IMemReady) begin
                check("fetch_addr", IMemAddr, exp_pc);
                e.pc  = exp_pc;
                e.ins = word(exp_pc);
                sbq.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic adv();
        @(negedge Clk);
    endtask

    task automatic cyc();
        sample();
        adv();
    endtask

    initial begin
        Reset = 1'b1; Reset_w = 1'b1; Stall = 1'b0;
        BranchTaken = 1'b0; BranchTarget = 32'h0;
        Jump = 1'b0; JumpTarget = 32'h0;
        IMemReady = 1'b1; IMemData = 32'h0; IMemData_w = 32'h0;
        exp_pc = 32'h0;
        adv();
        cyc();
        cyc();

        // Reset state, then the first request in the 2nd cycle.
        Reset = 1'b0;
        sample();
        check("rst_valid", InstrValid, 1'b0);
        check("rst_pc", PCResult, 32'h0);
        check("rst_instr", Instruction, 32'h0);
        check("rst_flush", Flush, 1'b0);
        check("rst_fault", Fault, 1'b0);
        check("rst_addr", IMemAddr, 32'h0);
        check("idle_noreq", IMemReq, 1'b0);
        adv();
        sample();
        check("first_req", IMemReq, 1'b1);
        adv();
        sample();
        check("seq_v0", InstrValid, 1'b1);
        check("seq_pc0", PCResult, 32'h0);
        adv();
        sample();
        check("seq_pc4", PCResult, 32'h4);
        adv();

        // Stall three cycles on PC 8.
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("stall_pc", PCResult, 32'h8);
            check("stall_instr", Instruction, word(32'h8));
            check("stall_noreq", IMemReq, 1'b0);
            adv();
        end
        Stall = 1'b0;
        sample();
        check("unstall_pc", PCResult, 32'h8);
        check("unstall_req", IMemReq, 1'b1);
        adv();
        sample();
        check("after_stall_pc", PCResult, 32'hC);
        adv();

        // Simultaneous branch and jump: branch wins.
        BranchTaken = 1'b1; BranchTarget = 32'h100;
        Jump = 1'b1; JumpTarget = 32'h200;
        sample();
        check("redir_noreq", IMemReq, 1'b0);
        sbq.delete();
        exp_pc = 32'h100;
        adv();
        BranchTaken = 1'b0; Jump = 1'b0;
        sample();
        check("redir_flush", Flush, 1'b1);
        check("redir_valid", InstrValid, 1'b0);
        check("redir_req", IMemReq, 1'b0);
        adv();
        sample();
        check("flush_once", Flush, 1'b0);
        check("new_addr", IMemAddr, 32'h100);
        check("new_req", IMemReq, 1'b1);
        adv();
        sample();
        check("new_pc", PCResult, 32'h100);
        adv();
        cyc();

        // Misaligned jump target faults.
        Jump = 1'b1; JumpTarget = 32'h202;
        sample();
        check("mis_noreq", IMemReq, 1'b0);
        sbq.delete();
        adv();
        Jump = 1'b0;
        sample();
        check("mis_fault", Fault, 1'b1);
        check("mis_req", IMemReq, 1'b0);
        check("mis_valid", InstrValid, 1'b0);
        check("mis_flush", Flush, 1'b0);
        adv();
        BranchTaken = 1'b1; BranchTarget = 32'h300;
        for (int i = 0; i < 3; i++) begin
            Stall = i[0];
            sample();
            check("fault_sticky", Fault, 1'b1);
            check("fault_noreq", IMemReq, 1'b0);
            adv();
        end
        BranchTaken = 1'b0; Stall = 1'b0;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        sample();
        check("clr_fault", Fault, 1'b0);
        check("clr_addr", IMemAddr, 32'h0);
        adv();

        // Timeout with stalled, non-requesting cycles first.
        sample();
        check("to_req0", IMemReq, 1'b1);
        adv();
        IMemReady = 1'b0;
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("to_stall_v", InstrValid, 1'b1);
            check("to_stall_noreq", IMemReq, 1'b0);
            adv();
        end
        Stall = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sample();
            check("to_req", IMemReq, 1'b1);
            check("to_nofault", Fault, 1'b0);
            adv();
        end
        sample();
        check("to_fault", Fault, 1'b1);
        check("to_noreq", IMemReq, 1'b0);
        adv();

        // Wrap instance, then reset in the middle of REQ.
        Reset = 1'b1;
        IMemReady = 1'b1;
        cyc();
        Reset_w = 1'b0;
        sample();
        check("w_idle", IMemReq_w, 1'b0);
        adv();
        sample();
        check("w_req", IMemReq_w, 1'b1);
        check("w_addr", IMemAddr_w, 32'hFFFF_FFF8);
        adv();
        sample();
        check("w_v", InstrValid_w, 1'b1);
        check("w_pc0", PCResult_w, 32'hFFFF_FFF8);
        check("w_ins0", Instruction_w, word(32'hFFFF_FFF8));
        adv();
        sample();
        check("w_pc1", PCResult_w, 32'hFFFF_FFFC);
        adv();
        Reset_w = 1'b1;
        sample();
        check("w_pc2", PCResult_w, 32'h0);
        check("w_ins2", Instruction_w, word(32'h0));
        check("w_req_mid", IMemReq_w, 1'b1);
        adv();
        sample();
        check("w_rst_req", IMemReq_w, 1'b0);
        check("w_rst_valid", InstrValid_w, 1'b0);
        check("w_flush", Flush_w, 1'b0);
        check("w_fault", Fault_w, 1'b0);
        adv();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
